// File: rtl/hwrot_dispatch.sv
// hwrot_dispatch: host-to-crypto-slot command dispatcher with base/stride decode,
// per-op FSM (done / timeout / abort) and a one-cycle slot clear pulse.
module hwrot_dispatch #(
  parameter int                   N_SLOTS     = 8,
  parameter int                   DATA_W      = 64,
  parameter logic [31:0]          BASE_ADDR   = 32'h0000_0020,
  parameter logic [31:0]          ADDR_STRIDE = 32'h0000_0010,
  parameter logic [15:0]          IMP_MASK    = 16'h00FF,
  parameter int                   TIMEOUT_W   = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 20'hFFFFF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [DATA_W-1:0]           i_data_in,
  input  logic [DATA_W-1:0]           i_add,
  input  logic [63:0]                 i_control,
  output logic [DATA_W-1:0]           o_data_out,
  output logic [1:0]                  o_end_op,
  output logic [N_SLOTS-1:0]          o_slot_en,
  output logic [N_SLOTS-1:0]          o_slot_clr,
  output logic [DATA_W-1:0]           o_slot_data_in,
  output logic [DATA_W-1:0]           o_slot_add,
  output logic [31:0]                 o_slot_control,
  input  logic [N_SLOTS*DATA_W-1:0]   i_slot_data_out,
  input  logic [N_SLOTS-1:0]          i_slot_end_op
);
  localparam int IW = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1;
  localparam int SH = $clog2(ADDR_STRIDE);
  typedef enum logic [2:0] {IDLE, BUSY, DONE, ABORT, TOUT} state_t;
  state_t state, nxt;
  logic [31:0] addr, cmd, off, quo;
  logic [IW-1:0] idx, idx_q;
  logic [TIMEOUT_W-1:0] timer, timer_inc;
  logic mapped, slot_end, sw, tmo, clr_hit;
  always_comb begin
    addr = i_control[63:32];
    cmd = i_control[31:0];
    off = addr - BASE_ADDR;
    quo = off >> SH;
    idx = quo[IW-1:0];
    mapped = addr >= BASE_ADDR && (off & (ADDR_STRIDE - 32'd1)) == '0 && quo < 32'(N_SLOTS) && IMP_MASK[quo[3:0]];
    slot_end = i_slot_end_op[idx_q];
    sw = !mapped || idx != idx_q;
    timer_inc = &timer ? timer : timer + 1'b1;
    tmo = TIMEOUT_CYC != '0 && timer_inc == TIMEOUT_CYC;
    clr_hit = state == BUSY && !slot_end && (sw || tmo);
    nxt = state;
    unique case (state)
      IDLE: nxt = (mapped && cmd != '0) ? BUSY : IDLE;
      BUSY: nxt = slot_end ? DONE : sw ? ABORT : tmo ? TOUT : BUSY;
      DONE, TOUT: nxt = (cmd == '0 || sw) ? IDLE : state;
      default: nxt = IDLE;
    endcase
    // an unmapped address always drops the op, whatever the state
    if (!mapped) nxt = IDLE;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      timer <= '0;
      idx_q <= '0;
      o_slot_en <= '0;
      o_slot_clr <= '0;
      o_slot_data_in <= '0;
      o_slot_add <= '0;
      o_slot_control <= '0;
      o_data_out <= '1;
      o_end_op <= 2'b11;
    end else begin
      state <= nxt;
      timer <= state == IDLE ? '0 : state == BUSY ? timer_inc : timer;
      if (mapped) idx_q <= idx;
      o_slot_en <= mapped ? N_SLOTS'(1) << idx : '0;
      o_slot_clr <= clr_hit ? N_SLOTS'(1) << idx_q : '0;
      o_slot_data_in <= i_data_in;
      o_slot_add <= i_add;
      o_slot_control <= cmd;
      o_data_out <= mapped ? i_slot_data_out[idx_q*DATA_W +: DATA_W] : '1;
      o_end_op <= !mapped ? 2'b11 : nxt == DONE ? 2'b01 : (nxt == ABORT || nxt == TOUT) ? 2'b10 : {1'b0, slot_end};
    end
  end
endmodule

// File: tb/tb_hwrot_dispatch.sv
// tb_hwrot_dispatch: directed checks of decode, done, timeout, abort and async reset.
module tb_hwrot_dispatch;
  logic clk = 1'b0;
  logic rst;
  logic [63:0] data_in, add, control, data_out, slot_data_in, slot_add;
  logic [1:0] end_op;
  logic [7:0] slot_en, slot_clr, slot_end_op;
  logic [31:0] slot_control;
  logic [511:0] slot_data_out;
  int n_cmp = 0;
  int n_err = 0;

  hwrot_dispatch #(.IMP_MASK(16'h00F7), .TIMEOUT_CYC(20'd16)) dut (
    .i_clk(clk), .i_rst(rst), .i_data_in(data_in), .i_add(add), .i_control(control),
    .o_data_out(data_out), .o_end_op(end_op), .o_slot_en(slot_en), .o_slot_clr(slot_clr),
    .o_slot_data_in(slot_data_in), .o_slot_add(slot_add), .o_slot_control(slot_control),
    .i_slot_data_out(slot_data_out), .i_slot_end_op(slot_end_op)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    data_in = '0;
    add = '0;
    control = '0;
    slot_end_op = '0;
    for (int i = 0; i < 8; i++) slot_data_out[i*64 +: 64] = 64'hD000_0000_0000_0000 | 64'(i);
    tick();
    chk("t1_end_op", 64'(end_op), 64'h3);
    chk("t1_data", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_en", 64'(slot_en), 64'h0);
    rst = 1'b0;
    control = {32'h30, 32'h0};
    tick();
    chk("t2_en_slot1", 64'(slot_en), 64'h02);
    chk("t2_end_idle", 64'(end_op), 64'h0);
    control = {32'h90, 32'h0};
    tick();
    chk("t2_en_slot7", 64'(slot_en), 64'h80);
    chk("t2_data_lag", data_out, 64'hD000_0000_0000_0001);
    tick();
    chk("t2_data_slot7", data_out, 64'hD000_0000_0000_0007);
    control = {32'h35, 32'h0};
    tick();
    chk("t2_misaligned_end", 64'(end_op), 64'h3);
    chk("t2_misaligned_en", 64'(slot_en), 64'h0);
    chk("t2_misaligned_data", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    control = {32'h10, 32'h0};
    tick();
    chk("t2_below_base", 64'(end_op), 64'h3);
    control = {32'hA0, 32'h0};
    tick();
    chk("t2_beyond_n", 64'(end_op), 64'h3);
    control = {32'h50, 32'h0};
    tick();
    chk("t2_masked_end", 64'(end_op), 64'h3);
    chk("t2_masked_en", 64'(slot_en), 64'h0);
    slot_data_out[64 +: 64] = 64'h1234;
    data_in = 64'hCAFE;
    add = 64'h8;
    control = {32'h30, 32'h1};
    tick();
    chk("t3_en", 64'(slot_en), 64'h02);
    chk("t3_busy_end", 64'(end_op), 64'h0);
    chk("t3_bc_ctrl", 64'(slot_control), 64'h1);
    chk("t3_bc_data", slot_data_in, 64'hCAFE);
    chk("t3_bc_add", slot_add, 64'h8);
    slot_end_op = 8'h02;
    tick();
    chk("t3_done_end", 64'(end_op), 64'h1);
    chk("t3_done_data", data_out, 64'h1234);
    slot_end_op = 8'h00;
    tick();
    chk("t3_done_hold", 64'(end_op), 64'h1);
    control = {32'h30, 32'h0};
    tick();
    chk("t3_back_idle", 64'(end_op), 64'h0);
    control = {32'h30, 32'h1};
    tick();
    tick(15);
    chk("t4_pre_clr", 64'(slot_clr), 64'h0);
    chk("t4_pre_end", 64'(end_op), 64'h0);
    tick();
    chk("t4_clr", 64'(slot_clr), 64'h02);
    chk("t4_end", 64'(end_op), 64'h2);
    tick();
    chk("t4_clr_once", 64'(slot_clr), 64'h0);
    tick();
    chk("t4_end_held", 64'(end_op), 64'h2);
    control = {32'h30, 32'h0};
    tick();
    chk("t4_release", 64'(end_op), 64'h0);
    control = {32'h30, 32'h1};
    tick(2);
    control = {32'h40, 32'h1};
    tick();
    chk("t5_clr", 64'(slot_clr), 64'h02);
    chk("t5_end", 64'(end_op), 64'h2);
    chk("t5_en", 64'(slot_en), 64'h04);
    tick();
    chk("t5_clr_once", 64'(slot_clr), 64'h0);
    chk("t5_end_once", 64'(end_op), 64'h0);
    tick();
    control = {32'h0, 32'h1};
    tick();
    chk("t5_unmapped_clr", 64'(slot_clr), 64'h04);
    chk("t5_unmapped_end", 64'(end_op), 64'h3);
    control = {32'h30, 32'h1};
    tick();
    tick(15);
    slot_end_op = 8'h02;
    tick();
    chk("t6_done_wins", 64'(end_op), 64'h1);
    chk("t6_no_clr", 64'(slot_clr), 64'h0);
    slot_end_op = 8'h00;
    control = {32'h30, 32'h0};
    tick();
    control = {32'h30, 32'h1};
    tick();
    chk("t6_busy_en", 64'(slot_en), 64'h02);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_en", 64'(slot_en), 64'h0);
    chk("t6_rst_end", 64'(end_op), 64'h3);
    chk("t6_rst_data", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t6_rst_clr", 64'(slot_clr), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
